// File: rtl/tube_event_builder.sv
// tube_event_builder
// Records hits on the 32 drift-tube channels over a look-back window and, on
// a scintillator coincidence, emits a 3-word event frame to the event FIFO.
//
// Ports:
//   clk100        in   system clock, 100 MHz
//   rst           in   asynchronous reset, active-high
//   SCIN_COIN     in   scintillator coincidence trigger (asynchronous)
//   TUBE3A..4B    in   8-bit tube discriminator hits (asynchronous)
//   WR_DATA       out  16-bit FIFO write data
//   WR_EN         out  FIFO write strobe, one word per high cycle
//   WR_FULL       in   FIFO full flag
//   overflowLight out  sticky lost-event indicator
//   busy          out  high while a frame is being emitted
//
// state | meaning
// IDLE  | waiting for a trigger edge
// HDR   | header word {4'hA, evt_cnt} on the write port
// W3    | {snap3A, snap3B} on the write port
// W4    | {snap4A, snap4B} on the write port
module tube_event_builder #(
  parameter int HIT_WINDOW = 16,
  parameter int EVT_CNT_W  = 12
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        SCIN_COIN,
  input  logic [7:0]  TUBE3A,
  input  logic [7:0]  TUBE3B,
  input  logic [7:0]  TUBE4A,
  input  logic [7:0]  TUBE4B,
  output logic [15:0] WR_DATA,
  output logic        WR_EN,
  input  logic        WR_FULL,
  output logic        overflowLight,
  output logic        busy
);

  localparam logic [7:0] HIT_LOAD = 8'(HIT_WINDOW);

  typedef enum logic [1:0] {IDLE, HDR, W3, W4} state_t;

  // bit 32 = SCIN_COIN, bits 31:0 = {3A, 3B, 4A, 4B}
  logic [32:0] raw;
  logic [32:0] sync1_q, sync1_d;
  logic [32:0] sync2_q, sync2_d;
  logic [32:0] sync3_q, sync3_d;
  logic [32:0] edge_det;

  logic [7:0]  hit_cnt_q [32];
  logic [7:0]  hit_cnt_d [32];
  logic [31:0] hot;

  state_t                 state_q, state_d;
  logic [31:0]            snap_q, snap_d;
  logic [EVT_CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   overflow_q, overflow_d;
  logic                   trig;

  assign raw = {SCIN_COIN, TUBE3A, TUBE3B, TUBE4A, TUBE4B};

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    edge_det = sync2_q & ~sync3_q;
    trig     = edge_det[32];
  end

  // Per-channel hit window: a new edge (re)loads, otherwise count down to 0.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      hit_cnt_d[i] = hit_cnt_q[i];
      if (edge_det[i])
        hit_cnt_d[i] = HIT_LOAD;
      else if (hit_cnt_q[i] != 8'd0)
        hit_cnt_d[i] = hit_cnt_q[i] - 8'd1;
      hot[i] = (hit_cnt_q[i] != 8'd0) || edge_det[i];
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      for (int i = 0; i < 32; i++) hit_cnt_q[i] <= '0;
      state_q    <= IDLE;
      snap_q     <= '0;
      evt_cnt_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      for (int i = 0; i < 32; i++) hit_cnt_q[i] <= hit_cnt_d[i];
      state_q    <= state_d;
      snap_q     <= snap_d;
      evt_cnt_q  <= evt_cnt_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state: state names the word currently on the port; it advances only
  // once that word has actually been strobed (wr_en_q).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trig && !WR_FULL) state_d = HDR;
      HDR:  if (wr_en_q) state_d = W3;
      W3:   if (wr_en_q) state_d = W4;
      W4:   if (wr_en_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered one cycle ahead so WR_EN and WR_DATA move together.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    snap_d     = snap_q;
    evt_cnt_d  = evt_cnt_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          snap_d    = hot;
          evt_cnt_d = evt_cnt_q + 1'b1;
          if (WR_FULL) begin
            overflow_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = {4'hA, evt_cnt_q};
          end
        end
      end
      HDR: begin
        if (wr_en_q) wr_data_d = snap_q[31:16];
        wr_en_d = !WR_FULL;
      end
      W3: begin
        if (wr_en_q) wr_data_d = snap_q[15:0];
        wr_en_d = !WR_FULL;
      end
      W4: begin
        wr_en_d = wr_en_q ? 1'b0 : !WR_FULL;
      end
      default: wr_en_d = 1'b0;
    endcase
    if (trig && state_q != IDLE) overflow_d = 1'b1;
  end

  assign busy          = (state_q != IDLE);
  assign WR_DATA       = wr_data_q;
  assign WR_EN         = wr_en_q;
  assign overflowLight = overflow_q;

endmodule

// File: tb/tb_tube_event_builder.sv
module tb_tube_event_builder;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        SCIN_COIN;
  logic [7:0]  TUBE3A, TUBE3B, TUBE4A, TUBE4B;
  logic [15:0] WR_DATA;
  logic        WR_EN;
  logic        WR_FULL;
  logic        overflowLight;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] wq[$];
  int          cq[$];

  tube_event_builder #(.HIT_WINDOW(16), .EVT_CNT_W(12)) dut (
    .clk100(clk100), .rst(rst), .SCIN_COIN(SCIN_COIN),
    .TUBE3A(TUBE3A), .TUBE3B(TUBE3B), .TUBE4A(TUBE4A), .TUBE4B(TUBE4B),
    .WR_DATA(WR_DATA), .WR_EN(WR_EN), .WR_FULL(WR_FULL),
    .overflowLight(overflowLight), .busy(busy)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc++;

  always @(negedge clk100) begin
    if (WR_EN && !rst) begin
      wq.push_back(WR_DATA);
      cq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete();
    cq.delete();
  endtask

  task automatic trig_pulse();
    @(negedge clk100) SCIN_COIN = 1'b1;
    @(negedge clk100) SCIN_COIN = 1'b0;
  endtask

  // TUBE3A[4] edge, then trigger edge exactly 'off' cycles later.
  task automatic hit_then_trig(input int off);
    @(negedge clk100) TUBE3A = 8'h10;
    for (int i = 1; i <= off; i++) begin
      @(negedge clk100);
      if (i == 3) TUBE3A = 8'h00;
    end
    SCIN_COIN = 1'b1;
    @(negedge clk100) SCIN_COIN = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] h,
                             input logic [15:0] a, input logic [15:0] b, input int gap);
    repeat (12 + gap) @(negedge clk100);
    chk({tag, "_nwords"}, wq.size(), 3);
    if (wq.size() >= 3) begin
      chk({tag, "_hdr"}, wq[0], h);
      chk({tag, "_w3"}, wq[1], a);
      chk({tag, "_w4"}, wq[2], b);
      chk({tag, "_gap1"}, cq[1] - cq[0], gap + 1);
      chk({tag, "_gap2"}, cq[2] - cq[1], 1);
    end
    chk({tag, "_busy_end"}, busy, 1'b0);
    clear_q();
  endtask

  task automatic wait_wr_en(input string tag);
    for (int i = 0; i < 10 && !WR_EN; i++) @(negedge clk100);
    chk({tag, "_wr_en_seen"}, WR_EN, 1'b1);
  endtask

  initial begin
    rst = 1'b1; SCIN_COIN = 1'b0; WR_FULL = 1'b0;
    TUBE3A = 8'h00; TUBE3B = 8'h00; TUBE4A = 8'h00; TUBE4B = 8'h00;
    repeat (3) @(negedge clk100);
    chk("rst_wr_data", WR_DATA, 16'h0000);
    chk("rst_wr_en", WR_EN, 1'b0);
    chk("rst_ovf", overflowLight, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk100);

    // Hit inside window, at the last hot cycle, and one cycle past it.
    clear_q(); hit_then_trig(6);
    check_frame("hit6", 16'hA000, 16'h1000, 16'h0000, 0);
    chk("hit6_ovf", overflowLight, 1'b0);
    clear_q(); hit_then_trig(16);
    check_frame("hit16", 16'hA001, 16'h1000, 16'h0000, 0);
    clear_q(); hit_then_trig(17);
    check_frame("hit17", 16'hA002, 16'h0000, 16'h0000, 0);

    // Staggered hits on all four groups.
    clear_q();
    @(negedge clk100) TUBE3A = 8'h10;
    repeat (2) @(negedge clk100);
    TUBE3A = 8'h00; TUBE3B = 8'h08;
    repeat (2) @(negedge clk100);
    TUBE3B = 8'h00; TUBE4A = 8'h02;
    repeat (2) @(negedge clk100);
    TUBE4A = 8'h00; TUBE4B = 8'h01;
    repeat (2) @(negedge clk100);
    TUBE4B = 8'h00;
    trig_pulse();
    check_frame("stagger", 16'hA003, 16'h1008, 16'h0201, 0);
    chk("stagger_ovf", overflowLight, 1'b0);

    // Trigger while FIFO full: event dropped, count consumed.
    clear_q();
    WR_FULL = 1'b1;
    trig_pulse();
    repeat (10) @(negedge clk100);
    chk("drop_nwords", wq.size(), 0);
    chk("drop_ovf", overflowLight, 1'b1);
    WR_FULL = 1'b0;

    // Stall for 5 cycles right after the header.
    clear_q();
    @(negedge clk100) TUBE3B = 8'h55;
    repeat (2) @(negedge clk100);
    TUBE3B = 8'h00;
    SCIN_COIN = 1'b1;
    @(negedge clk100) SCIN_COIN = 1'b0;
    wait_wr_en("stall");
    chk("stall_hdr_busy", busy, 1'b1);
    WR_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk100);
      chk($sformatf("stall_en_%0d", i), WR_EN, 1'b0);
      chk($sformatf("stall_data_%0d", i), WR_DATA, 16'h0055);
    end
    WR_FULL = 1'b0;
    check_frame("stall", 16'hA005, 16'h0055, 16'h0000, 5);

    // Reset clears the sticky overflow and the event counter.
    @(negedge clk100) rst = 1'b1;
    @(negedge clk100);
    chk("rst2_ovf", overflowLight, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk100);

    // Second trigger edge lands while the frame is in W3.
    clear_q();
    @(negedge clk100) SCIN_COIN = 1'b1;
    @(negedge clk100) SCIN_COIN = 1'b0;
    @(negedge clk100) SCIN_COIN = 1'b1;
    @(negedge clk100) SCIN_COIN = 1'b0;
    check_frame("dbl", 16'hA000, 16'h0000, 16'h0000, 0);
    chk("dbl_ovf", overflowLight, 1'b1);

    // Reset in the middle of a frame.
    clear_q();
    trig_pulse();
    wait_wr_en("midrst");
    chk("midrst_hdr", WR_DATA, 16'hA001);
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", WR_EN, 1'b0);
    chk("midrst_wr_data", WR_DATA, 16'h0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ovf", overflowLight, 1'b0);
    repeat (3) @(negedge clk100);
    rst = 1'b0;
    clear_q();
    repeat (10) @(negedge clk100);
    chk("midrst_no_words", wq.size(), 0);

    clear_q(); hit_then_trig(6);
    check_frame("post_rst", 16'hA000, 16'h1000, 16'h0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
